// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// word size, reset instruction value and the legal-PC helper.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Limit is computed in 33 bits so a window ending at 2^32 cannot wrap.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(depth) * 33'(WORD_BYTES));
    return (pc[1:0] == 2'b00) && (pc >= base) && ({1'b0, pc} < limit);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_perf_cnt.sv
// fetch_perf_cnt: two saturating event counters (accepted fetches, stall
// cycles) that hold their value while frozen.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetched,
  output logic [31:0] stall
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched <= 32'h0;
      stall   <= 32'h0;
    end else if (!freeze) begin
      if (fetch_inc && (fetched != 32'hFFFF_FFFF)) fetched <= fetched + 32'd1;
      if (stall_inc && (stall != 32'hFFFF_FFFF))   stall   <= stall + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads instr_mem and hands
// instructions to decode. Optional counters under FETCH_PERF_CNT_EN.
//
// Handshake: an instruction transfers to decode on every rising clk edge
// where out_valid && out_ready; while out_valid && !out_ready the outputs
// and the PC hold, and out_valid never drops without a transfer except on
// redirect flush, fault or reset.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        fault,
  output logic        halted,
  output logic [1:0]  fsm_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e state;
  logic [31:0]  pc_reg;
  logic         accept;

  assign accept    = out_valid && out_ready;
  assign imem_addr = pc_reg;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FS_IDLE;
      pc_reg    <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= NOP;
      out_pc    <= 32'h0;
      fault     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        FS_IDLE: state <= FS_FETCH;

        FS_FETCH: begin
          if (halt_req) begin
            // A held instruction survives the halt until decode takes it.
            state  <= FS_HALT;
            halted <= 1'b1;
            if (accept) out_valid <= 1'b0;
          end else if (redirect_valid) begin
            out_valid <= 1'b0;
            if (!pc_legal(redirect_pc, RESET_PC, MEM_DEPTH)) begin
              fault  <= 1'b1;
              halted <= 1'b1;
              state  <= FS_HALT;
            end else begin
              pc_reg <= redirect_pc;
            end
          end else if (!out_valid || out_ready) begin
            if (!pc_legal(pc_reg, RESET_PC, MEM_DEPTH)) begin
              fault     <= 1'b1;
              halted    <= 1'b1;
              state     <= FS_HALT;
              out_valid <= 1'b0;
            end else begin
              out_instr <= imem_rdata;
              out_pc    <= pc_reg;
              out_valid <= 1'b1;
              pc_reg    <= pc_reg + 32'(WORD_BYTES);
            end
          end
        end

        FS_HALT: if (accept) out_valid <= 1'b0;

        default: state <= FS_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .freeze    (state == FS_HALT),
    .fetch_inc (accept),
    .stall_inc (out_valid && !out_ready),
    .fetched   (perf_fetched),
    .stall     (perf_stall)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl with an 8-word instruction memory: directed
// scenarios plus randomized ready/redirect/halt traffic against a reference model.
`timescale 1ns/1ps
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned MEM_DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, redirect_pc;
  logic        out_valid, out_ready, redirect_valid, halt_req, fault, halted;
  logic [1:0]  fsm_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .fault(fault), .halted(halted), .fsm_state(fsm_state)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  // ---------------- instruction memory ----------------
  logic [31:0] mem [MEM_DEPTH];
  int unsigned mem_idx;
  always_comb begin
    mem_idx    = 0;
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_addr >= RESET_PC && imem_addr < RESET_PC + 32'(4 * MEM_DEPTH)) begin
      mem_idx    = int'((imem_addr - RESET_PC) >> 2);
      imem_rdata = mem[mem_idx];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic        m_started, m_valid, m_halted, m_fault;
  logic [31:0] m_pc, m_next, m_fetched, m_stall;
  int          acc_count, c_count;
  logic [31:0] last_acc_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic legal(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= RESET_PC) && (pc < RESET_PC + 4 * MEM_DEPTH);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_started = 0; m_valid = 0; m_halted = 0; m_fault = 0;
    m_pc = 0; m_next = RESET_PC; m_fetched = 0; m_stall = 0;
    acc_count = 0; c_count = 0; last_acc_pc = 32'hFFFF_FFFF;
  endtask

  // One clock edge of the fetch rules, using the inputs applied during the cycle.
  task automatic model_update();
    logic acc;
    acc = m_valid && out_ready;
    if (!m_halted) begin
      if (acc) m_fetched++;
      if (m_valid && !out_ready) m_stall++;
    end
    if (!m_started) m_started = 1;
    else if (m_halted) begin
      if (acc) m_valid = 0;
    end else if (halt_req) begin
      m_halted = 1;
      if (acc) m_valid = 0;
    end else if (redirect_valid) begin
      if (m_valid && !acc) exp_q.delete(exp_q.size() - 1);
      m_valid = 0;
      if (!legal(redirect_pc)) begin m_fault = 1; m_halted = 1; end
      else m_next = redirect_pc;
    end else if (!m_valid || out_ready) begin
      if (!legal(m_next)) begin
        m_fault = 1; m_halted = 1; m_valid = 0;
      end else begin
        m_valid = 1; m_pc = m_next;
        exp_q.push_back({m_next, mem[(m_next - RESET_PC) / 4]});
        m_next = m_next + 4;
      end
    end
  endtask

  // Monitor: mid-cycle compare of DUT state, pop on each handshake.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("fault", {31'b0, fault}, {31'b0, m_fault});
      check("halted", {31'b0, halted}, {31'b0, m_halted});
      check("imem_addr", imem_addr, m_next);
      if (m_halted) check("fsm_state_halt", {30'b0, fsm_state}, 32'd2);
      if (m_valid) check("out_pc", out_pc, m_pc);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_stall", perf_stall, m_stall);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL handshake_unexpected: got pc %h expected no transfer", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("acc_pc", out_pc, e[63:32]);
          check("acc_instr", out_instr, e[31:0]);
          acc_count++;
          last_acc_pc = out_pc;
          if (out_pc == 32'hC) c_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rst) model_update();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_fsm_state", {30'b0, fsm_state}, 32'd0);
    out_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    model_reset();
    out_ready = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
    #1;
    apply_reset();

    // 1: latency two edges, then sequential stream
    out_ready = 1;
    cycle();
    check("s1_idle_valid", {31'b0, out_valid}, 32'd0);
    cycle();
    check("s1_first_valid", {31'b0, out_valid}, 32'd1);
    check("s1_first_pc", out_pc, 32'h0);
    check("s1_first_instr", out_instr, mem[0]);
    cycle();
    check("s1_second_pc", out_pc, 32'h4);

    // 2: stall three cycles at pc 4
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("s2_stall_pc", out_pc, 32'h4);
      check("s2_stall_instr", out_instr, mem[1]);
      check("s2_stall_addr", imem_addr, 32'h8);
    end
    out_ready = 1;
    cycle();
    check("s2_release_pc", out_pc, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    check("s2_perf_stall", perf_stall, 32'd3);
`endif

    // 3: redirect while stalled flushes the held instruction
    out_ready = 0;
    cycle();
    redirect_valid = 1; redirect_pc = 32'h10;
    cycle();
    redirect_valid = 0; out_ready = 1;
    check("s3_flush_valid", {31'b0, out_valid}, 32'd0);
    cycle();
    check("s3_target_pc", out_pc, 32'h10);
    cycle();
    check("s3_target_next", out_pc, 32'h14);

    // 4: misaligned redirect faults; sequential run faults at the end of memory
    redirect_valid = 1; redirect_pc = 32'h6;
    cycle();
    redirect_valid = 0;
    check("s4_mis_fault", {31'b0, fault}, 32'd1);
    check("s4_mis_halted", {31'b0, halted}, 32'd1);
    check("s4_mis_valid", {31'b0, out_valid}, 32'd0);
    run(3);
    apply_reset();
    out_ready = 1;
    run(14);
    check("s4_range_fault", {31'b0, fault}, 32'd1);
    check("s4_range_count", 32'(acc_count), 32'd8);
    check("s4_range_last", last_acc_pc, 32'h1C);

    // 5: halt and redirect together with instruction 0xC pending
    apply_reset();
    out_ready = 1;
    guard = 0;
    while (!(m_valid && m_pc == 32'hC) && guard < 20) begin cycle(); guard++; end
    check("s5_reach_c", {31'b0, (guard < 20)}, 32'd1);
    out_ready = 0; halt_req = 1; redirect_valid = 1; redirect_pc = 32'h0;
    cycle();
    halt_req = 0; redirect_valid = 0;
    check("s5_halted", {31'b0, halted}, 32'd1);
    check("s5_held_pc", out_pc, 32'hC);
    cycle();
    out_ready = 1;
    run(3);
    check("s5_once", 32'(c_count), 32'd1);
    check("s5_valid_clear", {31'b0, out_valid}, 32'd0);

    // 6: reset asserted in the middle of a stall
    apply_reset();
    out_ready = 1;
    run(4);
    out_ready = 0;
    run(2);
    apply_reset();

    // Randomized traffic
    for (int ep = 0; ep < 5; ep++) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
      apply_reset();
      for (int c = 0; c < 80; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 3) == 0)
          redirect_pc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) | 32'h1 : 32'h40;
        else
          redirect_pc = 32'($urandom_range(0, MEM_DEPTH - 1)) * 4;
        halt_req = ($urandom_range(0, 59) == 0);
        cycle();
      end
      redirect_valid = 0; halt_req = 0; out_ready = 1;
      run(2);
      check("rand_queue_level", 32'(exp_q.size()), {31'b0, m_valid});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
